// File: rtl/data_read_axi_read.sv
// AXI4-Lite read slave for the acquisition block.
// Serves four registers: CR (reads as zero), SR (busy / sticky done / FIFO empty),
// DR (pops one word from the capture FIFO) and CNT (count of words popped since
// the last start). One transaction at a time, fixed four-state handshake.
module data_read_axi_read #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic        sr_busy,
    input  logic        sr_done,
    input  logic        cr_start,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CR  = 2'd0;
    localparam logic [1:0] SEL_SR  = 2'd1;
    localparam logic [1:0] SEL_DR  = 2'd2;
    localparam logic [1:0] SEL_CNT = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [1:0]             sel_q, sel_d;
    logic                   pop_q, pop_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   arready;
    logic                   rvalid;
    logic                   rd_en;
    logic [31:0]            cnt_ext;
    logic [31:0]            sr_word;

    // Only ARADDR[3:2] selects a register; the rest of the address is don't-care.
    logic unused_araddr;
    assign unused_araddr = ^{S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0]};

    // Zero-extend the counter to the 32-bit data bus, bit by bit.
    for (genvar gi = 0; gi < 32; gi++) begin : g_cnt_ext
        if (gi < CNT_WIDTH) begin : g_bit
            assign cnt_ext[gi] = cnt_q[gi];
        end else begin : g_zero
            assign cnt_ext[gi] = 1'b0;
        end
    end

    assign sr_word = {29'd0, fifo_empty, done_q, sr_busy};

    // Next-state and handshake outputs of the read FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pop_d   = pop_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (S_AXI_ARVALID) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Address handshake completes here; a DR read pops only if
                // there is something to pop, and remembers whether it did.
                arready = 1'b1;
                sel_d   = S_AXI_ARADDR[3:2];
                rd_en   = (S_AXI_ARADDR[3:2] == SEL_DR) && !fifo_empty;
                pop_d   = rd_en;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // fifo_dout is valid now, one cycle after the pop.
                rresp_d = RESP_OKAY;
                case (sel_q)
                    SEL_CR:  rdata_d = 32'd0;
                    SEL_SR:  rdata_d = sr_word;
                    SEL_DR: begin
                        if (pop_q) begin
                            rdata_d = fifo_dout;
                        end else begin
                            rdata_d = 32'd0;
                            rresp_d = RESP_SLVERR;
                        end
                    end
                    SEL_CNT: rdata_d = cnt_ext;
                    default: rdata_d = 32'd0;
                endcase
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rvalid = 1'b1;
                if (S_AXI_RREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky done flag and pop counter; a new done pulse beats a clearing read,
    // and a start coinciding with a pop leaves that pop counted.
    always_comb begin
        done_d = done_q;
        if (rvalid && S_AXI_RREADY && (sel_q == SEL_SR) && rdata_q[1]) begin
            done_d = 1'b0;
        end
        if (sr_done) begin
            done_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (cr_start) begin
            cnt_d = rd_en ? CNT_ONE : '0;
        end else if (rd_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            pop_q   <= 1'b0;
            rdata_q <= 32'd0;
            rresp_q <= 2'b00;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pop_q   <= pop_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign fifo_rd_en    = rd_en;

endmodule

// File: tb/tb_data_read_axi_read.sv
// Bench for data_read_axi_read: directed register-map table, multi-cycle corner
// sequences (sticky-done race, start/pop race, counter wrap, mid-read reset) and
// randomized reads checked against a queue-based register model.
module tb_data_read_axi_read;

    localparam int CW = 4;
    localparam int CNT_MASK = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        sr_busy;
    logic        sr_done;
    logic        cr_start;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;

    always #5 clk = ~clk;

    data_read_axi_read #(.CNT_WIDTH(CW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .sr_busy       (sr_busy),
        .sr_done       (sr_done),
        .cr_start      (cr_start),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en)
    );

    // Capture FIFO stand-in: data appears one cycle after the pop strobe.
    logic [31:0] fifo_mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    int          pop_count = 0;
    int          rd_en_bad = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pop_count <= pop_count + 1;
            if (!S_AXI_ARREADY || (wr_ptr == rd_ptr)) begin
                rd_en_bad <= rd_en_bad + 1;
            end else begin
                fifo_dout <= fifo_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 8'd1;
            end
        end
    end

    // Reference model of the register file.
    logic [31:0] exp_q [$];
    int          cnt_m  = 0;
    bit          done_m = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr;
        bit          busy;
        bit          pulse;
        int          npush;
        logic [31:0] d0;
        logic [31:0] d1;
        int          rwait;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } row_t;

    row_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic [31:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(d);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        sr_done = 1'b1;
        @(negedge clk);
        sr_done = 1'b0;
        done_m = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cr_start = 1'b1;
        @(negedge clk);
        cr_start = 1'b0;
        cnt_m = 0;
    endtask

    // One read with optional RREADY back-pressure, stray ARVALID pulses during
    // the response, sr_done on the handshake cycle and cr_start on the address cycle.
    task automatic do_read(input logic [31:0] addr, input int rwait, input bit done_hs,
                           input bit start, input string nm,
                           output logic [31:0] rd, output logic [1:0] rr);
        int n;
        int ar_hi;
        int stable_bad;
        logic [31:0] hold_d;
        logic [1:0]  hold_r;
        @(negedge clk);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        ar_hi = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            cr_start = 1'b0;
            if (S_AXI_RVALID) break;
            if (S_AXI_ARREADY) begin
                ar_hi++;
                cr_start = start;
            end else if (ar_hi > 0) begin
                S_AXI_ARVALID = 1'b0;
            end
        end
        S_AXI_ARVALID = 1'b0;
        cr_start = 1'b0;
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_arready_once"}, ar_hi, 1);
        rd = 32'hxxxx_xxxx;
        rr = 2'bxx;
        if (S_AXI_RVALID) begin
            hold_d = S_AXI_RDATA;
            hold_r = S_AXI_RRESP;
            stable_bad = 0;
            for (int i = 0; i < rwait; i++) begin
                S_AXI_ARVALID = i[0];
                @(posedge clk);
                #1;
                if (!(S_AXI_RVALID && S_AXI_RDATA === hold_d && S_AXI_RRESP === hold_r
                      && !S_AXI_ARREADY)) begin
                    stable_bad++;
                end
            end
            if (rwait > 0) chk({nm, "_resp_hold"}, stable_bad, 0);
            S_AXI_ARVALID = 1'b0;
            S_AXI_RREADY  = 1'b1;
            sr_done       = done_hs;
            @(posedge clk);
            #1;
            S_AXI_RREADY = 1'b0;
            sr_done      = 1'b0;
            chk({nm, "_rvalid_drop"}, 32'(S_AXI_RVALID), 0);
            @(posedge clk);
            #1;
            chk({nm, "_no_stray_ar"}, 32'(S_AXI_ARREADY), 0);
            rd = hold_d;
            rr = hold_r;
        end
    endtask

    // Runs a read, compares to the model (or to the given constants), and
    // advances the model.
    task automatic run_txn(input logic [31:0] addr, input int rwait, input bit done_hs,
                           input bit start, input bit use_model,
                           input logic [31:0] t_d, input logic [1:0] t_r, input string nm);
        logic [1:0]  sel;
        logic [31:0] m_d;
        logic [1:0]  m_r;
        int          m_pop;
        int          p0;
        logic [31:0] rd;
        logic [1:0]  rr;
        sel   = addr[3:2];
        m_r   = 2'b00;
        m_pop = 0;
        case (sel)
            2'd0: m_d = 32'd0;
            2'd1: m_d = {29'd0, exp_q.size() == 0, done_m, sr_busy};
            2'd2: begin
                if (exp_q.size() > 0) begin
                    m_d   = exp_q[0];
                    m_pop = 1;
                end else begin
                    m_d = 32'd0;
                    m_r = 2'b10;
                end
            end
            default: m_d = cnt_m & CNT_MASK;
        endcase
        p0 = pop_count;
        do_read(addr, rwait, done_hs, start, nm, rd, rr);
        $display("txn %s addr=%h rdata=%h rresp=%0d", nm, addr, rd, rr);
        chk({nm, "_rdata"}, rd, use_model ? m_d : t_d);
        chk({nm, "_rresp"}, 32'(rr), 32'(use_model ? m_r : t_r));
        chk({nm, "_pops"}, pop_count - p0, m_pop);
        if (m_pop == 1) void'(exp_q.pop_front());
        if (start) cnt_m = m_pop;
        else       cnt_m = (cnt_m + m_pop) & CNT_MASK;
        if (done_hs) done_m = 1'b1;
        else if (sel == 2'd1 && m_d[1]) done_m = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [31:0] a;
        logic [1:0]  sel;
        int r;

        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0000, 2'b00};
        tbl[1]  = '{32'hFFFF_FFF3, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0000, 2'b00};
        tbl[2]  = '{32'h0000_0004, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1,  32'h0000_0004, 2'b00};
        tbl[3]  = '{32'h0000_0004, 1'b1, 1'b1, 2, 32'hDEAD_BEEF, 32'h1234_5678, 10,
                    32'h0000_0003, 2'b00};
        tbl[4]  = '{32'h0000_0004, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0001, 2'b00};
        tbl[5]  = '{32'h0000_0008, 1'b1, 1'b0, 0, 32'h0, 32'h0, 2,  32'hDEAD_BEEF, 2'b00};
        tbl[6]  = '{32'hABCD_000A, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0,  32'h1234_5678, 2'b00};
        tbl[7]  = '{32'h0000_000C, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0002, 2'b00};
        tbl[8]  = '{32'h0000_0008, 1'b1, 1'b0, 0, 32'h0, 32'h0, 3,  32'h0000_0000, 2'b10};
        tbl[9]  = '{32'h0000_001C, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0002, 2'b00};
        tbl[10] = '{32'h0000_0004, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0,  32'h0000_0005, 2'b00};

        rst_n         = 1'b0;
        S_AXI_ARADDR  = 32'd0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        sr_busy       = 1'b0;
        sr_done       = 1'b0;
        cr_start      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({S_AXI_ARREADY, S_AXI_RVALID, fifo_rd_en, S_AXI_RRESP}), 0);
        chk("reset_rdata", S_AXI_RDATA, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed register-map table.
        for (int i = 0; i < 11; i++) begin
            sr_busy = tbl[i].busy;
            if (tbl[i].pulse) pulse_done();
            if (tbl[i].npush >= 1) push(tbl[i].d0);
            if (tbl[i].npush >= 2) push(tbl[i].d1);
            run_txn(tbl[i].addr, tbl[i].rwait, 1'b0, 1'b0, 1'b0,
                    tbl[i].exp_d, tbl[i].exp_r, $sformatf("tbl%0d", i));
        end

        // sr_done on the clearing handshake: the flag survives.
        pulse_done();
        run_txn(32'h4, 0, 1'b1, 1'b0, 1'b0, 32'h7, 2'b00, "done_race1");
        run_txn(32'h4, 0, 1'b0, 1'b0, 1'b0, 32'h7, 2'b00, "done_race2");
        run_txn(32'h4, 0, 1'b0, 1'b0, 1'b0, 32'h5, 2'b00, "done_race3");

        // cr_start on the same cycle as a pop leaves CNT at 1.
        push(32'hCAFE_F00D);
        run_txn(32'h8, 0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b00, "start_pop");
        run_txn(32'hC, 0, 1'b0, 1'b0, 1'b0, 32'h1, 2'b00, "start_pop_cnt");

        // Counter wraps after 2^CW pops.
        pulse_start();
        for (int i = 0; i < 17; i++) push($urandom);
        for (int i = 0; i < 17; i++) run_txn(32'h8, 0, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, "wrap");
        run_txn(32'hC, 0, 1'b0, 1'b0, 1'b0, 32'h1, 2'b00, "wrap_cnt");

        // Reset in the middle of a DR read.
        sr_busy = 1'b0;
        pulse_done();
        run_txn(32'h4, 0, 1'b1, 1'b0, 1'b0, 32'h6, 2'b00, "pre_rst_sr");
        push(32'h5555_AAAA);
        p0 = pop_count;
        @(negedge clk);
        S_AXI_ARADDR  = 32'h8;
        S_AXI_ARVALID = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_addr_phase", 32'(S_AXI_ARREADY), 1);
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({S_AXI_ARREADY, S_AXI_RVALID, fifo_rd_en, S_AXI_RRESP}), 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_pop", pop_count - p0, 1);
        void'(exp_q.pop_front());
        cnt_m  = 0;
        done_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pop_count;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_pop", pop_count - p0, 0);
        chk("rst_idle", 32'({S_AXI_ARREADY, S_AXI_RVALID}), 0);
        run_txn(32'hC, 0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, "rst_cnt");
        run_txn(32'h4, 0, 1'b0, 1'b0, 1'b0, 32'h4, 2'b00, "rst_sr");

        // Randomized reads against the model.
        for (int i = 0; i < 40; i++) begin
            sr_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pulse_done();
            if ($urandom_range(0, 9) == 0) pulse_start();
            if (exp_q.size() < 6) begin
                r = $urandom_range(0, 2);
                for (int k = 0; k < r; k++) push($urandom);
            end
            r = $urandom_range(0, 5);
            sel = (r >= 4) ? 2'd2 : 2'(r);
            a = $urandom;
            a[3:2] = sel;
            run_txn(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), 1'b1, 32'h0, 2'b00,
                    $sformatf("rnd%0d", i));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rd_en_outside_addr", rd_en_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
